if_id_queue: RTL and testbench



---
 rtl/if_id_queue_pkg.sv | 13 +
 rtl/if_id_queue.sv | 77 +++++++
 tb/tb_if_id_queue.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/if_id_queue_pkg.sv
// Shared configuration for the fetch-to-decode instruction queue.
// Holds the pc width, the canonical NOP bubble and the boolean literals.
package if_id_queue_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0 -- presented to decode whenever the queue is empty
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

endpackage

// File: rtl/if_id_queue.sv
// Small FIFO of {pc, instruction} pairs between fetch and decode.
// Empties on flush or reset in one cycle and shows a NOP bubble when empty.
//
// Handshake: on both sides a transfer happens on a rising edge where valid and
// ready are both high; ready never depends on the same side's valid, and
// if_ready depends only on the stored count (no full-queue pass-through).
module if_id_queue #(
  parameter int XLEN = if_id_queue_pkg::XLEN,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_flag,
  input  logic             if_valid,
  input  logic [XLEN-1:0]  if_pc,
  input  logic [31:0]      if_instr,
  output logic             if_ready,
  output logic             id_valid,
  output logic [XLEN-1:0]  id_pc,
  output logic [31:0]      id_instr,
  input  logic             id_ready,
  output logic [PTR_W:0]   occupancy
);

  import if_id_queue_pkg::*;

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [XLEN-1:0]  pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic push;
  logic pop;
  logic clear;

  assign if_ready  = (count == FULL_COUNT) ? FALSE : TRUE;
  assign id_valid  = (count != '0) ? TRUE : FALSE;
  assign occupancy = count;

  assign push  = if_valid & if_ready;
  assign pop   = id_valid & id_ready;
  assign clear = rst | flush_flag;

  // Head is read straight from the registers; no bypass from the fetch side.
  assign id_pc    = id_valid ? pc_mem[rd_ptr]    : '0;
  assign id_instr = id_valid ? instr_mem[rd_ptr] : NOP_INSTR;

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      pc_mem[wr_ptr]    <= if_pc;
      instr_mem[wr_ptr] <= if_instr;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally at DEPTH-1 -> 0.
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for the fetch-to-decode instruction queue.
// Expected entries are queued when a push is driven and popped when decode consumes.
module tb_if_id_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h00000013;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush_flag = 1'b0;
  logic             if_valid = 1'b0;
  logic [XLEN-1:0]  if_pc = '0;
  logic [31:0]      if_instr = '0;
  logic             if_ready;
  logic             id_valid;
  logic [XLEN-1:0]  id_pc;
  logic [31:0]      id_instr;
  logic             id_ready = 1'b0;
  logic [PTR_W:0]   occupancy;

  logic [XLEN+31:0] exp_q[$];
  logic [XLEN+31:0] got_head;
  logic [XLEN+31:0] exp_head;
  logic             popped;
  int               n_cmp = 0;
  int               n_err = 0;

  if_id_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush_flag(flush_flag),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr), .id_ready(id_ready),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Driver: apply one cycle of stimulus, update the scoreboard, land 1 ns past the edge.
  task automatic cycle(input logic v, input logic [XLEN-1:0] pc, input logic [31:0] instr,
                       input logic rdy, input logic fl);
    logic do_pop;
    logic do_push;
    if_valid = v; if_pc = pc; if_instr = instr; id_ready = rdy; flush_flag = fl;
    do_pop  = rdy && exp_q.size() != 0 && !fl && !rst;
    do_push = v && exp_q.size() < DEPTH && !fl && !rst;
    popped = do_pop;
    if (do_pop) begin
      got_head = {id_pc, id_instr};
      exp_head = exp_q.pop_front();
    end
    if (do_push) exp_q.push_back({pc, instr});
    if (fl || rst) exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, '0, '0, rdy, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle(1'b0);
    idle(1'b0);
    rst = 1'b0;
    n_cmp++; if (if_ready !== 1'b1) begin n_err++; $display("FAIL reset_if_ready: got %b want 1", if_ready); end
    n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL reset_id_valid: got %b want 0", id_valid); end
    n_cmp++; if (id_pc !== '0) begin n_err++; $display("FAIL reset_id_pc: got %h want 0", id_pc); end
    n_cmp++; if (id_instr !== NOP) begin n_err++; $display("FAIL reset_id_instr: got %h want %h", id_instr, NOP); end
    n_cmp++; if (occupancy !== '0) begin n_err++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
  endtask

  task automatic test_push_pop;
    cycle(1'b1, 32'h0, 32'h00100093, 1'b0, 1'b0);
    if_valid = 1'b0;
    n_cmp++; if (id_valid !== 1'b1) begin n_err++; $display("FAIL pp_id_valid: got %b want 1", id_valid); end
    n_cmp++; if (id_pc !== 32'h0) begin n_err++; $display("FAIL pp_id_pc: got %h want 0", id_pc); end
    n_cmp++; if (id_instr !== 32'h00100093) begin n_err++; $display("FAIL pp_id_instr: got %h want 00100093", id_instr); end
    n_cmp++; if (occupancy !== 2'd1) begin n_err++; $display("FAIL pp_occupancy: got %0d want 1", occupancy); end
    idle(1'b1);
    n_cmp++; if (!popped || got_head !== exp_head) begin n_err++; $display("FAIL pp_pop: got %h want %h", got_head, exp_head); end
    n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL pp_empty: got %b want 0", id_valid); end
  endtask

  task automatic test_fill;
    cycle(1'b1, 32'h0, 32'h11111111, 1'b0, 1'b0);
    cycle(1'b1, 32'h4, 32'h22222222, 1'b0, 1'b0);
    n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL fill_occupancy: got %0d want 2", occupancy); end
    n_cmp++; if (if_ready !== 1'b0) begin n_err++; $display("FAIL fill_if_ready: got %b want 0", if_ready); end
    cycle(1'b1, 32'h8, 32'h33333333, 1'b0, 1'b0);
    n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL full_drop_occ: got %0d want 2", occupancy); end
    n_cmp++; if (id_pc !== 32'h0) begin n_err++; $display("FAIL full_hold_pc: got %h want 0", id_pc); end
    idle(1'b1);
    n_cmp++; if (!popped || got_head !== exp_head) begin n_err++; $display("FAIL fill_pop0: got %h want %h", got_head, exp_head); end
    idle(1'b1);
    n_cmp++; if (!popped || got_head !== exp_head) begin n_err++; $display("FAIL fill_pop1: got %h want %h", got_head, exp_head); end
    n_cmp++; if (id_valid !== 1'b0 || occupancy !== '0) begin n_err++; $display("FAIL fill_empty: got valid %b occ %0d want 0 0", id_valid, occupancy); end
    idle(1'b1);
    n_cmp++; if (id_valid !== 1'b0 || occupancy !== '0) begin n_err++; $display("FAIL empty_pop: got valid %b occ %0d want 0 0", id_valid, occupancy); end
  endtask

  task automatic test_stream;
    int n_pops = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, XLEN'(i * 4), $urandom, 1'b1, 1'b0);
      if (popped) begin
        n_pops++;
        n_cmp++; if (got_head !== exp_head) begin n_err++; $display("FAIL stream_head: got %h want %h", got_head, exp_head); end
      end
      n_cmp++; if (occupancy !== (PTR_W + 1)'(exp_q.size())) begin n_err++; $display("FAIL stream_occ: got %0d want %0d", occupancy, exp_q.size()); end
    end
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      if (popped) begin
        n_pops++;
        n_cmp++; if (got_head !== exp_head) begin n_err++; $display("FAIL stream_drain: got %h want %h", got_head, exp_head); end
      end
    end
    n_cmp++; if (n_pops != 10) begin n_err++; $display("FAIL stream_count: got %0d want 10", n_pops); end
    n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL stream_empty: got %b want 0", id_valid); end
  endtask

  task automatic test_flush;
    cycle(1'b1, 32'h10, 32'haaaa0013, 1'b0, 1'b0);
    cycle(1'b1, 32'h14, 32'hbbbb0013, 1'b0, 1'b0);
    cycle(1'b1, 32'h100, 32'hcccc0013, 1'b0, 1'b1);
    n_cmp++; if (occupancy !== '0) begin n_err++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
    n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", id_valid); end
    idle(1'b1);
    n_cmp++; if (id_valid !== 1'b0 || id_pc === 32'h100) begin n_err++; $display("FAIL flush_drop: got valid %b pc %h want 0", id_valid, id_pc); end
    cycle(1'b1, 32'h20, 32'hdddd0013, 1'b0, 1'b0);
    idle(1'b1);
    n_cmp++; if (!popped || got_head !== exp_head) begin n_err++; $display("FAIL flush_after: got %h want %h", got_head, exp_head); end
  endtask

  task automatic test_reset_mid;
    cycle(1'b1, 32'h40, 32'h12340013, 1'b0, 1'b0);
    cycle(1'b1, 32'h44, 32'h56780013, 1'b0, 1'b0);
    n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL rmid_pre: got %0d want 2", occupancy); end
    rst = 1'b1;
    idle(1'b1);
    rst = 1'b0;
    n_cmp++; if (occupancy !== '0 || id_valid !== 1'b0) begin n_err++; $display("FAIL rmid_empty: got occ %0d valid %b want 0 0", occupancy, id_valid); end
    n_cmp++; if (if_ready !== 1'b1) begin n_err++; $display("FAIL rmid_if_ready: got %b want 1", if_ready); end
    n_cmp++; if (id_instr !== NOP) begin n_err++; $display("FAIL rmid_nop: got %h want %h", id_instr, NOP); end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 60; i++) begin
      cycle($urandom_range(0, 1) == 1, XLEN'($urandom), $urandom, $urandom_range(0, 2) != 0, 1'b0);
      if (popped) begin
        n_cmp++; if (got_head !== exp_head) begin n_err++; $display("FAIL b2b_head: got %h want %h", got_head, exp_head); end
      end
      n_cmp++; if (occupancy !== (PTR_W + 1)'(exp_q.size()) || occupancy > DEPTH) begin n_err++; $display("FAIL b2b_occ: got %0d want %0d", occupancy, exp_q.size()); end
      n_cmp++; if (if_ready !== (exp_q.size() < DEPTH)) begin n_err++; $display("FAIL b2b_if_ready: got %b want %b", if_ready, exp_q.size() < DEPTH); end
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset;
    test_push_pop;
    test_fill;
    test_stream;
    test_flush;
    test_reset_mid;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
